array_sorter: RTL and testbench
===============================

ARRAY_SORTER -- requirements
Module: array_sorter

Interface
REQ-001 Parameter ADDR_W, default 5, sets the memory address width; array depth is 2**ADDR_W entries.
REQ-002 Parameter DATA_W, default 8, sets the element width; elements are unsigned.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, independent of clk).
REQ-005 start  input  1  active-high sort request, sampled only in IDLE, held high by the user until done.
REQ-006 ready  output  1  high only in IDLE.
REQ-007 done  output  1  high only in DONE; array in memory is then ascending.
REQ-008 address  output  ADDR_W  address to the external single-port RAM shared with the downstream searcher.
REQ-009 wr_data  output  DATA_W  write data to RAM.
REQ-010 wren  output  1  RAM write enable, active-high.
REQ-011 rd_data  input  DATA_W  RAM read data, valid the cycle after the address is presented (1-cycle read latency).
REQ-012 swaps  output  ADDR_W*2-1  number of swaps performed in the current/last sort (max 496 at defaults).

Function
REQ-013 The block SHALL sort the RAM in place into ascending order by bubble sort before the downstream binary searcher runs.
REQ-014 States: IDLE, RDA, RDB, CMP, WRA, WRB, DONE.
REQ-015 IDLE: ready=1; on start=1 the block SHALL clear i, swapped, swaps, set limit=2**ADDR_W-1, go to RDA.
REQ-016 RDA: address=i, wren=0; go to RDB.
REQ-017 RDB: address=i+1, wren=0; register a<=rd_data; go to CMP.
REQ-018 CMP: register b<=rd_data; compare using the value being registered; if a>b go to WRA, else advance (REQ-021).
REQ-019 WRA: address=i, wr_data=b, wren=1; go to WRB.
REQ-020 WRB: address=i+1, wr_data=a, wren=1; set swapped=1, swaps+=1; advance.
REQ-021 Advance: if i+1<limit then i+=1, go RDA; else end of pass.
REQ-022 End of pass: if swapped=0 or limit=1 go DONE; else limit-=1, i=0, swapped=0, go RDA.
REQ-023 Equal elements SHALL NOT be swapped (a=b is not a>b).
REQ-024 Comparison without swap costs 3 cycles, with swap 5 cycles; no idle cycles between comparisons or passes.
REQ-025 DONE: done=1, address held at 0, wren=0; stay while start=1; return to IDLE when start=0.
REQ-026 start changes outside IDLE/DONE SHALL be ignored; sort runs to completion.
REQ-027 wren SHALL be high only in WRA/WRB; the block never writes outside addresses 0..2**ADDR_W-1.
REQ-028 i+1 SHALL NOT wrap: the largest address read is limit, which is at most 2**ADDR_W-1.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, ready=1, done=0, wren=0, address=0, wr_data=0, swaps=0, i=0, limit=0, swapped=0.
REQ-030 Reset mid-sort SHALL abort without completing a pending write; RAM may be partially sorted; a new start resorts fully.
REQ-031 After reset release, start=1 on the first posedge SHALL be accepted.

Verification
REQ-032 RAM=0..31 ascending, start -> done rises 94 cycles after start edge, swaps=0, wren never high.
REQ-033 RAM=31..0 descending -> RAM ascending 0..31 at done, swaps=496.
REQ-034 RAM ascending with entries 0 and 1 exchanged -> swaps=1, two passes, done after 93+2+90+1 cycles.
REQ-035 RAM all 8'd7 -> swaps=0, RAM unchanged, one pass.
REQ-036 reset=0 during WRA of a reverse-sorted run -> same cycle ready=1, wren=0, swaps=0; restart yields ascending RAM.
REQ-037 start held after done -> done stays 1; start=0 -> IDLE and ready=1 next cycle; downstream searcher then finds 8'd0 at address 0.

Source files
------------

// File: rtl/array_sorter.sv
// rtl/array_sorter.sv - in-place bubble sorter for an external single-port RAM
//
// Sorts a 2**ADDR_W entry RAM of unsigned DATA_W elements into ascending
// order before the downstream binary searcher uses the same RAM.
//
// Ports:
//   clk      - single clock, all state changes on its rising edge
//   reset    - asynchronous active-low reset
//   start    - sort request, sampled in IDLE, held high by the user until done
//   ready    - high only while idle
//   done     - high only once the sort has finished (RAM is ascending)
//   address  - RAM address (shared single-port RAM)
//   wr_data  - RAM write data
//   wren     - RAM write enable, active-high
//   rd_data  - RAM read data, valid the cycle after address is presented
//   swaps    - number of swaps performed in the current/last sort

module array_sorter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  wren,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [2*ADDR_W-2:0]   swaps
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_WRA  = 3'd4;
  localparam logic [2:0] S_WRB  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  // Last index of the array; the first pass compares up to this entry.
  localparam logic [ADDR_W-1:0] LIMIT_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] LIMIT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] limit;
  logic              swapped;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;

  // i+1 in the pass width; never wraps because i < limit <= LIMIT_MAX
  // whenever it is used as an address.
  logic [ADDR_W-1:0] i_plus1;
  // i+1 with a carry bit so the end-of-pass compare is exact.
  logic [ADDR_W:0]   i_plus1_wide;
  logic              more_in_pass;
  logic              pass_swapped;
  logic              need_swap;

  // Outcome of "advance" (shared by CMP without swap and WRB).
  logic [2:0]        adv_state;
  logic [ADDR_W-1:0] adv_i;
  logic [ADDR_W-1:0] adv_limit;
  logic              adv_swapped;

  assign i_plus1      = i + 1'b1;
  assign i_plus1_wide = {1'b0, i} + {{ADDR_W{1'b0}}, 1'b1};
  assign more_in_pass = (i_plus1_wide < {1'b0, limit});

  // The swap being completed in WRB counts toward the current pass even
  // though the swapped register only updates on the same edge.
  assign pass_swapped = swapped | (state == S_WRB);

  // Compare against the value being registered into b this cycle, so no
  // extra cycle is spent waiting for b.  Equal elements are left in place.
  assign need_swap = (a > rd_data);

  always_comb begin
    adv_state   = S_RDA;
    adv_i       = i;
    adv_limit   = limit;
    adv_swapped = pass_swapped;
    if (more_in_pass) begin
      adv_state = S_RDA;
      adv_i     = i_plus1;
    end else if (!pass_swapped || (limit == LIMIT_ONE)) begin
      adv_state = S_DONE;
    end else begin
      // Largest remaining element has bubbled to position limit.
      adv_state   = S_RDA;
      adv_i       = '0;
      adv_limit   = limit - 1'b1;
      adv_swapped = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      i       <= '0;
      limit   <= '0;
      swapped <= 1'b0;
      swaps   <= '0;
      a       <= '0;
      b       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            i       <= '0;
            swapped <= 1'b0;
            swaps   <= '0;
            limit   <= LIMIT_MAX;
            state   <= S_RDA;
          end
        end
        S_RDA: begin
          state <= S_RDB;
        end
        S_RDB: begin
          a     <= rd_data;
          state <= S_CMP;
        end
        S_CMP: begin
          b <= rd_data;
          if (need_swap) begin
            state <= S_WRA;
          end else begin
            state   <= adv_state;
            i       <= adv_i;
            limit   <= adv_limit;
            swapped <= adv_swapped;
          end
        end
        S_WRA: begin
          state <= S_WRB;
        end
        S_WRB: begin
          swaps   <= swaps + 1'b1;
          state   <= adv_state;
          i       <= adv_i;
          limit   <= adv_limit;
          swapped <= adv_swapped;
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from state so an asynchronous reset takes
  // them to their idle values without waiting for a clock.
  always_comb begin
    ready   = (state == S_IDLE);
    done    = (state == S_DONE);
    wren    = 1'b0;
    address = '0;
    wr_data = '0;
    case (state)
      S_RDA: begin
        address = i;
      end
      S_RDB, S_CMP: begin
        address = i_plus1;
      end
      S_WRA: begin
        address = i;
        wr_data = b;
        wren    = 1'b1;
      end
      S_WRB: begin
        address = i_plus1;
        wr_data = a;
        wren    = 1'b1;
      end
      default: begin
        address = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_array_sorter.sv
// tb/tb_array_sorter.sv - self-checking bench for array_sorter with a RAM model

module tb_array_sorter;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int N  = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic          ready;
  logic          done;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic          wren;
  logic [DW-1:0] rd_data;
  logic [2*AW-2:0] swaps;

  array_sorter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ready   (ready),
    .done    (done),
    .address (address),
    .wr_data (wr_data),
    .wren    (wren),
    .rd_data (rd_data),
    .swaps   (swaps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency; bench loading port has priority.
  logic [DW-1:0] mem [N];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [DW-1:0] tb_wdata;
  logic [DW-1:0] rd_q;

  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (wren) mem[address] <= wr_data;
    rd_q <= mem[address];
  end
  assign rd_data = rd_q;

  typedef struct {
    int kind;        // 0 asc, 1 desc, 2 asc with 0/1 exchanged, 3 all 7, 4 random, 5 random small range
    int exp_swaps;   // -1: take from inversion count
    int exp_cycles;  // 0: not checked
  } vec_t;

  typedef struct {
    int               swaps;
    int               cycles;
    logic [N*DW-1:0]  sorted;
  } sb_t;

  sb_t sb_q[$];
  int  pat [N];
  int  checks;
  int  errors;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic make_pattern(input int kind);
    for (int k = 0; k < N; k++) begin
      case (kind)
        0: pat[k] = k;
        1: pat[k] = N - 1 - k;
        2: pat[k] = (k == 0) ? 1 : ((k == 1) ? 0 : k);
        3: pat[k] = 7;
        4: pat[k] = int'($urandom_range(255, 0));
        default: pat[k] = int'($urandom_range(3, 0));
      endcase
    end
  endtask

  task automatic load_ram();
    for (int k = 0; k < N; k++) begin
      tb_we    = 1'b1;
      tb_addr  = AW'(k);
      tb_wdata = DW'(pat[k]);
      @(posedge clk);
      #1;
    end
    tb_we = 1'b0;
  endtask

  // Expected result: inversion count (= bubble sort swaps) and an
  // insertion-sorted copy of the pattern.
  task automatic push_expected(input int exp_swaps, input int exp_cycles);
    sb_t e;
    int  s [N];
    int  inv;
    int  t;
    inv = 0;
    for (int x = 0; x < N; x++)
      for (int y = x + 1; y < N; y++)
        if (pat[x] > pat[y]) inv++;
    for (int k = 0; k < N; k++) s[k] = pat[k];
    for (int x = 1; x < N; x++) begin
      t = s[x];
      for (int y = x - 1; y >= 0; y--) begin
        if (s[y] > t) begin
          s[y+1] = s[y];
          s[y]   = t;
        end
      end
    end
    e.swaps  = (exp_swaps < 0) ? inv : exp_swaps;
    e.cycles = exp_cycles;
    e.sorted = '0;
    for (int k = 0; k < N; k++) e.sorted[k*DW +: DW] = DW'(s[k]);
    sb_q.push_back(e);
  endtask

  // Raise start, wait for done, compare against the scoreboard head, hold
  // start for hold cycles, then drop it and confirm the return to idle.
  task automatic run_one(input string nm, input int hold);
    sb_t e;
    int  cyc;
    int  wr;
    int  busy_bad;
    int  bad;
    bit  got;
    start    = 1'b1;
    cyc      = 0;
    wr       = 0;
    busy_bad = 0;
    got      = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (wren) wr++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (ready) busy_bad++;
    end
    e = sb_q.pop_front();
    chk({nm, "_done_reached"}, got, 1);
    if (e.cycles != 0) chk({nm, "_cycles"}, cyc, e.cycles);
    chk({nm, "_swaps"}, swaps, e.swaps);
    chk({nm, "_write_cycles"}, wr, 2 * e.swaps);
    chk({nm, "_ready_while_busy"}, busy_bad, 0);
    bad = 0;
    for (int k = 0; k < N; k++)
      if (mem[k] !== e.sorted[k*DW +: DW]) bad++;
    chk({nm, "_ram_mismatches"}, bad, 0);
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b1 || wren !== 1'b0) bad++;
    end
    if (hold > 0) chk({nm, "_done_held"}, bad, 0);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_ready_after"}, ready, 1);
    chk({nm, "_done_after"}, done, 0);
  endtask

  vec_t vecs [6];

  initial begin
    int seen;
    checks   = 0;
    errors   = 0;
    start    = 1'b0;
    tb_we    = 1'b0;
    tb_addr  = '0;
    tb_wdata = '0;
    reset    = 1'b0;

    vecs[0] = '{kind: 0, exp_swaps: 0,   exp_cycles: 94};
    vecs[1] = '{kind: 1, exp_swaps: 496, exp_cycles: 2481};
    vecs[2] = '{kind: 2, exp_swaps: 1,   exp_cycles: 186};
    vecs[3] = '{kind: 3, exp_swaps: 0,   exp_cycles: 94};
    vecs[4] = '{kind: 4, exp_swaps: -1,  exp_cycles: 0};
    vecs[5] = '{kind: 5, exp_swaps: -1,  exp_cycles: 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",   ready,   1);
    chk("rst_done",    done,    0);
    chk("rst_wren",    wren,    0);
    chk("rst_address", address, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_swaps",   swaps,   0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      make_pattern(vecs[v].kind);
      load_ram();
      push_expected(vecs[v].exp_swaps, vecs[v].exp_cycles);
      run_one($sformatf("vec%0d", v), 0);
    end

    // Reset in the middle of a reverse-sorted run, on its first WRA.
    make_pattern(1);
    load_ram();
    start = 1'b1;
    seen  = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (wren) begin
        seen = 1;
        break;
      end
    end
    chk("midrst_wra_seen", seen, 1);
    reset = 1'b0;
    #1;
    chk("midrst_ready",   ready,   1);
    chk("midrst_wren",    wren,    0);
    chk("midrst_swaps",   swaps,   0);
    chk("midrst_address", address, 0);
    chk("midrst_done",    done,    0);
    #1;
    reset = 1'b1;
    // No write landed, so the RAM still holds the reversed data; start is
    // presented for the very first edge after release.
    push_expected(496, 2481);
    run_one("restart", 0);

    // Start held after done, then the searcher reads address 0.
    make_pattern(2);
    load_ram();
    push_expected(1, 186);
    run_one("hold", 5);
    @(posedge clk);
    #1;
    chk("search_addr0", address, 0);
    chk("search_rd_data", rd_data, 0);

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
